// File: rtl/fft_bitrev_pair_loader.sv
// fft_bitrev_pair_loader
// Input stage of the real-input radix-2 DIT FFT. A frame of N_FFT real
// samples is captured in natural order. It is then replayed as N_FFT/2
// operand pairs in bit-reversed order, one pair per cycle, straight into
// the first-stage butterfly.
//
// Pair k carries x[bitrev(2k)] and x[bitrev(2k)+N/2]. Because 2k is even,
// bitrev(2k) always has its MSB clear. The B address is therefore the
// A address with the MSB set.

module fft_bitrev_pair_loader #(
    parameter int Q_IN   = 15,
    parameter int N_FFT  = 256,
    parameter int LOG2_N = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [Q_IN:0]       sample_in,
    output logic                in_ready,
    output logic                valid_out,
    output logic [Q_IN:0]       a_real,
    output logic [Q_IN:0]       b_real,
    output logic [LOG2_N-2:0]   pair_idx,
    output logic                frame_done
);

    localparam int RD_W = LOG2_N - 1;

    // Counter terminal values and increments. N_FFT is a power of two,
    // so the last index is all ones.
    localparam logic [LOG2_N-1:0] WR_LAST = {LOG2_N{1'b1}};
    localparam logic [RD_W-1:0]   RD_LAST = {RD_W{1'b1}};
    localparam logic [LOG2_N-1:0] WR_ONE  = LOG2_N'(1'b1);
    localparam logic [RD_W-1:0]   RD_ONE  = RD_W'(1'b1);
    localparam logic [LOG2_N-1:0] HALF    = {1'b1, {RD_W{1'b0}}};

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state_r;
    logic [LOG2_N-1:0]   wr_cnt_r;
    logic [RD_W-1:0]     rd_cnt_r;
    logic [Q_IN:0]       mem_r [0:N_FFT-1];

    logic                accept_s;
    logic [LOG2_N-1:0]   rd_addr_a_s;
    logic [LOG2_N-1:0]   rd_addr_b_s;

    // Reverse the bit order of an LOG2_N-bit address.
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        r = {LOG2_N{1'b0}};
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = v[LOG2_N-1-i];
        end
        return r;
    endfunction

    assign in_ready = (state_r == LOAD);

    // Handshake and read-address generation for the current pair.
    always_comb begin
        accept_s    = in_valid && (state_r == LOAD);
        rd_addr_a_s = bitrev({rd_cnt_r, 1'b0});
        rd_addr_b_s = rd_addr_a_s | HALF;
    end

    // Frame buffer write port. Its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_cnt_r] <= sample_in;
        end
    end

    // Control FSM and registered pair outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= LOAD;
            wr_cnt_r   <= {LOG2_N{1'b0}};
            rd_cnt_r   <= {RD_W{1'b0}};
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            a_real     <= {(Q_IN+1){1'b0}};
            b_real     <= {(Q_IN+1){1'b0}};
            pair_idx   <= {RD_W{1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    valid_out  <= 1'b0;
                    frame_done <= 1'b0;
                    if (in_valid) begin
                        wr_cnt_r <= wr_cnt_r + WR_ONE;
                        if (wr_cnt_r == WR_LAST) begin
                            state_r <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    a_real     <= mem_r[rd_addr_a_s];
                    b_real     <= mem_r[rd_addr_b_s];
                    pair_idx   <= rd_cnt_r;
                    valid_out  <= 1'b1;
                    frame_done <= (rd_cnt_r == RD_LAST);
                    rd_cnt_r   <= rd_cnt_r + RD_ONE;
                    if (rd_cnt_r == RD_LAST) begin
                        state_r <= LOAD;
                    end
                end
                default: begin
                    state_r    <= LOAD;
                    wr_cnt_r   <= {LOG2_N{1'b0}};
                    rd_cnt_r   <= {RD_W{1'b0}};
                    valid_out  <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
